// File: rtl/cordic_exp_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : cordic_exp_dispatch
// Description : Upstream sequencer for a pair of exponential CORDIC cores.
//               A 16.16 signed argument arrives on a valid/ready stream. Its
//               sign bit picks either the positive-argument core or the
//               negative-argument core. The sequencer drives that core's
//               reset and enable, waits for its done flag and holds the
//               32.32 result on a valid/ready output stream. A job that runs
//               too long is aborted with an error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT      maximum RUN cycles per job before abort (>= 1)
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   in_valid_i   argument offered
//   in_ready_o   argument accepted when in_valid_i & in_ready_o
//   in_x_i       argument, signed 16.16
//   out_valid_o  result held
//   out_ready_i  result consumed when out_valid_o & out_ready_i
//   out_y_o      result, unsigned 32.32 (raw core output), 0 on timeout
//   out_err_o    1 = job timed out
//   p_x_o        argument to the positive core
//   p_rst_o      positive core reset
//   p_en_o       positive core enable
//   p_y_i        positive core result
//   p_valid_i    positive core done (held until p_rst_o)
//   n_x_o        argument to the negative core
//   n_rst_o      negative core reset
//   n_en_o       negative core enable
//   n_y_i        negative core result
//   n_valid_i    negative core done (held until n_rst_o)
// ============================================================================
module cordic_exp_dispatch #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_x_i,

    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_y_o,
    output logic        out_err_o,

    output logic [31:0] p_x_o,
    output logic        p_rst_o,
    output logic        p_en_o,
    input  logic [63:0] p_y_i,
    input  logic        p_valid_i,

    output logic [31:0] n_x_o,
    output logic        n_rst_o,
    output logic        n_en_o,
    input  logic [63:0] n_y_i,
    input  logic        n_valid_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int           CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      x_q,     x_d;
    logic [63:0]      y_q,     y_d;
    logic             err_q,   err_d;

    // Core selection follows the captured argument, not the live input, so
    // the choice cannot change while a job is in flight.
    logic             sel_n;
    logic             sel_valid;
    logic [63:0]      sel_y;

    assign sel_n     = x_q[31];
    assign sel_valid = sel_n ? n_valid_i : p_valid_i;
    assign sel_y     = sel_n ? n_y_i     : p_y_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    x_d     = in_x_i;
                    state_d = S_CLEAR;
                end
            end

            // One cycle with both cores held in reset and the argument
            // already stable, so the selected core starts from a clean state.
            // Any valid seen here is stale and deliberately not looked at.
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end

            // Core valid takes priority over the timeout when both land in
            // the same cycle.
            S_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (sel_valid) begin
                    y_d     = sel_y;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            // Held until the consumer takes the result; no timeout here.
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Control outputs are gated by rst directly so the cores are held in
    // reset, and no handshake is offered, during the reset cycle itself
    // rather than only from the following cycle.
    logic w_run;

    assign w_run       = (state_q == S_RUN) && !rst;

    assign in_ready_o  = (state_q == S_IDLE) && !rst;
    assign out_valid_o = (state_q == S_DONE) && !rst;
    assign out_y_o     = y_q;
    assign out_err_o   = err_q;

    assign p_x_o       = x_q;
    assign n_x_o       = x_q;

    assign p_en_o      = w_run && !sel_n;
    assign p_rst_o     = !p_en_o;
    assign n_en_o      = w_run && sel_n;
    assign n_rst_o     = !n_en_o;

endmodule
`default_nettype wire

// File: tb/tb_cordic_exp_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_exp_dispatch
// Description : Self-checking bench for cordic_exp_dispatch. Two mock cores
//               assert done after a programmed number of enabled cycles. A
//               job-timeline model predicts every output each cycle, and
//               directed jobs pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_exp_dispatch;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_x_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [63:0] out_y_o;
    logic        out_err_o;
    logic [31:0] p_x_o, n_x_o;
    logic        p_rst_o, p_en_o, n_rst_o, n_en_o;
    logic [63:0] p_y_i, n_y_i;
    logic        p_valid_i, n_valid_i;

    always #5 clk = ~clk;

    cordic_exp_dispatch #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_x_i(in_x_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_y_o(out_y_o), .out_err_o(out_err_o),
        .p_x_o(p_x_o), .p_rst_o(p_rst_o), .p_en_o(p_en_o),
        .p_y_i(p_y_i), .p_valid_i(p_valid_i),
        .n_x_o(n_x_o), .n_rst_o(n_rst_o), .n_en_o(n_en_o),
        .n_y_i(n_y_i), .n_valid_i(n_valid_i)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Mock cores: done after D enabled cycles (valid in the D-th enabled
    // cycle), result presented only while done. Random junk on valid while
    // the core is not enabled must be ignored by the DUT.
    // ------------------------------------------------------------------------
    int          p_d = 1, n_d = 1;
    logic [63:0] p_yc = '0, n_yc = '0;
    int          p_cnt = 0, n_cnt = 0;
    logic        p_done = 1'b0, n_done = 1'b0;
    logic        p_junk = 1'b0, n_junk = 1'b0;
    logic        p_mv, n_mv;

    always @(posedge clk) begin
        if (p_rst_o) begin
            p_cnt  <= 0;
            p_done <= 1'b0;
        end else if (p_en_o) begin
            p_cnt <= p_cnt + 1;
            if (p_cnt == p_d - 1) p_done <= 1'b1;
        end
        if (n_rst_o) begin
            n_cnt  <= 0;
            n_done <= 1'b0;
        end else if (n_en_o) begin
            n_cnt <= n_cnt + 1;
            if (n_cnt == n_d - 1) n_done <= 1'b1;
        end
    end

    assign p_mv      = p_done | (p_en_o & (p_cnt == p_d - 1));
    assign n_mv      = n_done | (n_en_o & (n_cnt == n_d - 1));
    assign p_valid_i = p_mv | (p_junk & ~p_en_o);
    assign n_valid_i = n_mv | (n_junk & ~n_en_o);
    assign p_y_i     = p_mv ? p_yc : ~p_yc;
    assign n_y_i     = n_mv ? n_yc : ~n_yc;

    always @(posedge clk) begin
        #3;
        p_junk = 1'($urandom % 2);
        n_junk = 1'($urandom % 2);
    end

    // out_ready policy: 0 = always high, 1 = random, 2 = held low
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        out_ready_i = (rdy_mode == 0) ? 1'b1 :
                      (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end

    // ------------------------------------------------------------------------
    // Job-timeline model. t counts cycles since the accept edge: t=1 is the
    // clear cycle, the next R cycles run the core, then the result is held.
    // R and the result come straight from the mock's delay vs. the timeout.
    // ------------------------------------------------------------------------
    logic        m_busy = 1'b0;
    int          m_t = 0, m_R = 0, m_D = 0;
    logic        m_sel = 1'b0;
    logic [31:0] m_x = '0;
    logic [63:0] m_y = '0;
    logic        m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_x    = '0;
            m_y    = '0;
            m_err  = 1'b0;
        end else if (!m_busy) begin
            if (in_valid_i) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_x    = in_x_i;
                m_sel  = in_x_i[31];
                m_D    = m_sel ? n_d : p_d;
                if (m_D <= TO) begin
                    m_R   = m_D;
                    m_y   = m_sel ? n_yc : p_yc;
                    m_err = 1'b0;
                end else begin
                    m_R   = TO;
                    m_y   = '0;
                    m_err = 1'b1;
                end
            end
        end else if (m_t >= 2 + m_R && out_ready_i) begin
            m_busy = 1'b0;
        end else begin
            m_t++;
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------------
    int   p_starts = 0, n_starts = 0;
    logic p_en_prev = 1'b0, n_en_prev = 1'b0;
    logic e_run, e_done, e_pen, e_nen;

    always @(negedge clk) begin
        e_run  = !rst && m_busy && m_t >= 2 && m_t < 2 + m_R;
        e_done = !rst && m_busy && m_t >= 2 + m_R;
        e_pen  = e_run && !m_sel;
        e_nen  = e_run && m_sel;
        chk("in_ready",  in_ready_o,  !rst && !m_busy);
        chk("out_valid", out_valid_o, e_done);
        chk("p_en",      p_en_o,      e_pen);
        chk("p_rst",     p_rst_o,     !e_pen);
        chk("n_en",      n_en_o,      e_nen);
        chk("n_rst",     n_rst_o,     !e_nen);
        chk("p_x",       p_x_o,       m_x);
        chk("n_x",       n_x_o,       m_x);
        if (e_done) begin
            chk("out_y",   out_y_o,   m_y);
            chk("out_err", out_err_o, m_err);
        end
        if (p_en_o && !p_en_prev) p_starts++;
        if (n_en_o && !n_en_prev) n_starts++;
        p_en_prev = p_en_o;
        n_en_prev = n_en_o;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    // Offers x and returns just after the accept edge (posedge + 2).
    task automatic start_job(input logic [31:0] x, input int gap);
        logic ok;
        ok = 1'b0;
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #2;
        in_valid_i = 1'b1;
        in_x_i     = x;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready_o) begin
                @(posedge clk);
                #2;
                in_valid_i = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            in_valid_i = 1'b0;
            chk("accept_timeout", 0, 1);
        end
    endtask

    // Waits for out_valid; run = enabled cycles, lat = cycles from accept.
    task automatic wait_result(output int run, output int lat,
                               output logic [63:0] y, output logic err);
        logic got;
        got = 1'b0;
        run = 0;
        lat = 0;
        y   = '0;
        err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid_o) begin
                y   = out_y_o;
                err = out_err_o;
                got = 1'b1;
                break;
            end
            if (p_en_o || n_en_o) run++;
        end
        if (!got) chk("result_timeout", 0, 1);
    endtask

    task automatic wait_release();
        logic gone;
        gone = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!out_valid_o) begin
                gone = 1'b1;
                break;
            end
        end
        if (!gone) chk("release_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    int          run, lat, ps0, ns0;
    logic [63:0] y, y2;
    logic        err;
    logic [31:0] rx;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  in_ready_o,  0);
        chk("rst_p_rst",     p_rst_o,     1);
        chk("rst_n_rst",     n_rst_o,     1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_y",     out_y_o,     0);
        chk("rst_out_err",   out_err_o,   0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready_o, 1);

        // 1: positive core, 40 cycles
        p_d = 40; p_yc = 64'h0031_E199_5F00_0000;
        ns0 = n_starts;
        start_job(32'h000F_0000, 0);
        wait_result(run, lat, y, err);
        chk("t1_run", run, 40);
        chk("t1_lat", lat, 42);
        chk("t1_y", y, 64'h0031_E199_5F00_0000);
        chk("t1_err", err, 0);
        chk("t1_n_unused", n_starts - ns0, 0);
        wait_release();

        // 2: negative core, 10 cycles
        n_d = 10; n_yc = 64'h0000_0000_5E2D_58D8;
        ps0 = p_starts;
        start_job(32'hFFFF_0000, 1);
        wait_result(run, lat, y, err);
        chk("t2_run", run, 10);
        chk("t2_y", y, 64'h0000_0000_5E2D_58D8);
        chk("t2_err", err, 0);
        chk("t2_p_unused", p_starts - ps0, 0);
        wait_release();

        // 3: core never completes -> timeout after exactly TO run cycles
        p_d = 1000;
        start_job(32'h0000_0000, 0);
        wait_result(run, lat, y, err);
        chk("t3_run", run, 64);
        chk("t3_lat", lat, 66);
        chk("t3_y", y, 0);
        chk("t3_err", err, 1);
        wait_release();

        // 3b: valid on the last allowed cycle wins over timeout
        n_d = TO; n_yc = 64'h0000_0001_2345_6789;
        start_job(32'h8000_0000, 0);
        wait_result(run, lat, y, err);
        chk("t3b_run", run, 64);
        chk("t3b_y", y, 64'h0000_0001_2345_6789);
        chk("t3b_err", err, 0);
        wait_release();

        // 4: result held with out_ready low while a new input is offered
        rdy_mode = 2; p_d = 3; p_yc = 64'h0000_0004_0000_0000;
        start_job(32'h0002_0000, 0);
        wait_result(run, lat, y, err);
        chk("t4_run", run, 3);
        in_valid_i = 1'b1;
        in_x_i     = 32'h1234_5678;
        repeat (20) begin
            @(negedge clk);
            chk("t4_hold_y", out_y_o, 64'h0000_0004_0000_0000);
            chk("t4_hold_in_ready", in_ready_o, 0);
        end
        rdy_mode = 0;
        @(posedge clk);
        #2;
        in_valid_i = 1'b0;
        wait_release();
        chk("t4_idle_in_ready", in_ready_o, 1);

        // 5: reset mid-run discards the job, next job runs normally
        p_d = 1000;
        start_job(32'h0005_0000, 0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", in_ready_o, 1);
        chk("t5_p_rst", p_rst_o, 1);
        chk("t5_out_valid", out_valid_o, 0);
        p_d = 5; p_yc = 64'h0000_0002_B7E1_5162;
        start_job(32'h0001_0000, 0);
        wait_result(run, lat, y, err);
        chk("t5_run", run, 5);
        chk("t5_y", y, 64'h0000_0002_B7E1_5162);
        wait_release();

        // 6: back-to-back jobs, one per core
        p_d = 7; p_yc = 64'h0000_0007_6399_2E35;
        n_d = 4; n_yc = 64'h0000_0000_22A5_5529;
        ps0 = p_starts; ns0 = n_starts;
        start_job(32'h0002_0000, 0);
        wait_result(run, lat, y, err);
        start_job(32'hFFFE_0000, 0);
        wait_result(run, lat, y2, err);
        wait_release();
        chk("t6_first", y, 64'h0000_0007_6399_2E35);
        chk("t6_second", y2, 64'h0000_0000_22A5_5529);
        chk("t6_p_once", p_starts - ps0, 1);
        chk("t6_n_once", n_starts - ns0, 1);

        // Random jobs with random out_ready and occasional reset aborts
        rdy_mode = 1;
        for (int j = 0; j < 40; j++) begin
            case ($urandom % 5)
                0:       rx = 32'h0000_0000;
                1:       rx = 32'h8000_0000;
                default: rx = $urandom;
            endcase
            p_d  = $urandom_range(1, 80);
            n_d  = $urandom_range(1, 80);
            p_yc = {$urandom, $urandom};
            n_yc = {$urandom, $urandom};
            start_job(rx, $urandom_range(0, 3));
            if ($urandom % 6 == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                @(posedge clk);
                #2;
                rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
            end else begin
                wait_result(run, lat, y, err);
                wait_release();
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
